// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier controller.
// One 4-bit ripple-carry adder is time-shared over four add/shift iterations.

module ripple_add4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] cy_s;

  assign cy_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]    = a[i] ^ b[i] ^ cy_s[i];
    assign cy_s[i+1] = (a[i] & b[i]) | (cy_s[i] & (a[i] ^ b[i]));
  end

  assign carry = cy_s[WIDTH];

endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'd3;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 c_q, c_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_b_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 carry_s;
  logic                 msb_s;

  assign add_b_s = q_q[0] ? m_q : {WIDTH{1'b0}};

  ripple_add4 #(.WIDTH(WIDTH)) u_add (
    .a     (acc_q),
    .b     (add_b_s),
    .sum   (sum_s),
    .carry (carry_s)
  );

  // C is cleared on load and after every shift, so only the adder carry reaches the MSB.
  assign msb_s = carry_s | c_q;

  // Next-state, operand capture and add/shift datapath.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = {WIDTH{1'b0}};
          c_d     = 1'b0;
          cnt_d   = 2'd0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        acc_d = {msb_s, sum_s[WIDTH-1:1]};
        q_d   = {sum_s[0], q_q[WIDTH-1:1]};
        c_d   = 1'b0;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          product_d = {msb_s, sum_s[WIDTH-1:1], sum_s[0], q_q[WIDTH-1:1]};
          state_d   = S_DONE;
        end else begin
          state_d   = S_ADD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= {WIDTH{1'b0}};
      acc_q     <= {WIDTH{1'b0}};
      q_q       <= {WIDTH{1'b0}};
      c_q       <= 1'b0;
      cnt_q     <= 2'd0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_ADD);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: expected products and done cycles
// are queued when a start is driven and compared every falling edge.

module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       busy;
  logic       done;
  logic [7:0] product;

  typedef struct {
    logic [7:0] prod;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_prod = 8'h00;

  shift_add_mult_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: busy/done timing and product value derived from the queued operations.
  always @(negedge clk) begin
    logic eb;
    logic ed;
    eb = 1'b0;
    ed = 1'b0;
    if (sb.size() > 0) begin
      eb = (cyc >= sb[0].acc) && (cyc < sb[0].acc + 4);
      ed = (cyc == sb[0].acc + 4);
    end
    check_eq("busy", 32'(busy), 32'(eb));
    check_eq("done", 32'(done), 32'(ed));
    if (ed) begin
      exp_prod = sb[0].prod;
      void'(sb.pop_front());
    end
    check_eq("product", 32'(product), 32'(exp_prod));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive start for one cycle; the rising edge that follows accepts it.
  task automatic issue(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    a_i    = x;
    b_i    = y;
    start  = 1'b1;
    e.prod = {4'b0000, x} * {4'b0000, y};
    e.acc  = cyc + 1;
    sb.push_back(e);
    step(1);
    start  = 1'b0;
  endtask

  initial begin
    logic [7:0] pair;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = 4'd0;
    b_i   = 4'd0;
    step(2);
    rst = 1'b0;
    step(3);

    // Single operations, including extremes.
    issue(4'd3, 4'd5);   step(5);
    issue(4'hF, 4'hF);   step(5);
    issue(4'h0, 4'hA);   step(5);
    issue(4'h9, 4'h1);   step(5);

    // Back-to-back: second start presented during the DONE cycle.
    issue(4'd7, 4'd6);   step(4);
    issue(4'd2, 4'd8);   step(5);

    // start and operand changes during ADD must be ignored.
    issue(4'd5, 4'd11);
    start = 1'b1;
    a_i   = 4'hF;
    b_i   = 4'hF;
    step(2);
    start = 1'b0;
    step(3);

    // Reset in the second ADD cycle aborts with no done pulse.
    issue(4'd13, 4'd12);
    step(1);
    rst = 1'b1;
    sb.delete();
    exp_prod = 8'h00;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    issue(4'd4, 4'd4);   step(5);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 256; i++) begin
      pair = 8'(i);
      issue(pair[7:4], pair[3:0]);
      step(4);
    end
    step(3);

    check_eq("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
